execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Pipeline stage directly downstream of the register-read stage.
- Consumes the registered operands, instruction word, valid flag (condition) and load/store flag.
- Performs the ALU operation, address generation or multiply; resolves operand forwarding; registers the result for memory/writeback.
- Asserts stall upstream while an iterative multiply is in progress.

Parameters:
DATA_W, 32, datapath width
REG_AW, 4, register address width (16 registers)
MUL_CYCLES, 32, iterations of the radix-2 shift-add multiplier

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
valid_in  input  1  instruction present (register-stage condition output)
ls_in  input  1  load/store flag from register stage
instruction_in  input  32  instruction word
op_a  input  DATA_W  register operand A (rn)
op_b  input  DATA_W  register operand B (rm / store data)
src_a  input  REG_AW  register number of op_a
src_b  input  REG_AW  register number of op_b
wb_valid  input  1  writeback-stage write enable, forwarding source
wb_reg  input  REG_AW  writeback destination register
wb_data  input  DATA_W  writeback data
result  output  DATA_W  ALU result or memory address
store_data  output  DATA_W  forwarded op_b, for STR
dest_reg  output  REG_AW  destination register
wr_en  output  1  result must be written to dest_reg
mem_rd  output  1  LDR issued
mem_wr  output  1  STR issued
valid_out  output  1  output bundle valid
flags  output  4  N,Z,C,V (bit 3..0)
stall  output  1  upstream must hold its outputs

Behaviour:
- Reset (async, active-high): all outputs 0; FSM to IDLE; multiplier registers cleared. Reset mid-multiply aborts the operation with no output.
- Instruction fields: [31:28] opcode, [27] I (operand2 = zero-extended imm[13:0]), [26] S (update flags), [25:22] rd, [21:18] rn, [17:14] rm, [13:0] imm.
- Opcodes:
  - 0 ADD, 1 SUB (a-b), 2 AND, 3 ORR, 4 EOR, 5 MOV (operand2).
  - 6 LSL, 7 LSR: amount = operand2[5:0]; amount >= 32 gives 0.
  - 8 CMP: SUB, flags only, wr_en=0.
  - 9 MUL: low 32 bits of product.
  - A LDR: result = a+imm, mem_rd=1, wr_en=1.
  - B STR: result = a+imm, mem_wr=1, wr_en=0.
  - C-F NOP: valid_out=1, wr_en=0.
  - LDR/STR are honoured only when ls_in=1; otherwise they execute as NOP.
- Forwarding, combinational on inputs:
  - If the previous output has valid_out and wr_en and is not mem_rd, and dest_reg==src_x, use result (EX->EX).
  - Else if wb_valid and wb_reg==src_x, use wb_data.
  - Else use the register value.
  - EX->EX has priority over writeback.
- Latency: single-cycle ops produce registered outputs one cycle after valid_in is sampled.
- valid_in=0: valid_out=0, wr_en=0, mem_rd=0, mem_wr=0 next cycle; result and flags hold.
- Flags:
  - Updated only when S=1 or opcode=CMP.
  - N = result[31]; Z = (result==0).
  - ADD: C = carry-out, V = signed overflow.
  - SUB/CMP: C = no borrow (a>=b unsigned), V = signed overflow.
  - Logic/shift/MOV/MUL: C and V unchanged.
- Multiply FSM, states IDLE, BUSY, DONE:
  - IDLE->BUSY when valid_in and opcode=9: latch forwarded operands; stall=1 combinationally in the issuing cycle; valid_out=0.
  - BUSY: one shift-add step per cycle; counter runs 0..MUL_CYCLES-1; stall=1.
  - At last step -> DONE: stall=0; outputs registered (valid_out=1, wr_en=1, result = product) on the DONE->IDLE edge.
  - Total MUL latency = MUL_CYCLES+1 cycles.
- While stall=1, inputs are ignored; the upstream stage holds them.
- Back-to-back MULs restart from IDLE.
- wb forwarding is sampled only at MUL issue.

Optional Feature:
- EXEC_FAST_MUL_EN defined: MUL completes in one cycle like other ops; stall is tied to 0; FSM and counter are removed.
- EXEC_FAST_MUL_EN undefined: iterative FSM as above.
- Results are identical in both builds; only latency and stall differ.

Decomposition:
- Package exec_pkg: opcode constants (OP_ADD..OP_STR), instruction field bit positions, FSM state encoding, flag bit indices.
- Sub-module mul_iter: iterative multiplier with start/busy/done handshake, instantiated only when EXEC_FAST_MUL_EN is undefined.

Test Plan:
- Reset mid-MUL: reset at BUSY cycle 10 -> all outputs 0, stall=0 immediately; next ADD proceeds normally.
- ADD with S=1, a=0x7FFFFFFF, b=1 -> result=0x80000000, flags N=1 Z=0 C=0 V=1 after 1 cycle; CMP a=5, b=5 -> Z=1 C=1, wr_en=0.
- Forwarding:
  - ADD r1=r2+r3 then ADD r4=r1+r1 back-to-back -> second uses EX result.
  - With wb_valid, wb_reg=1, wb_data=0x10 also present -> EX value wins.
- MUL 7*6 (iterative) -> stall high for 33 cycles; result=42, valid_out=1 on cycle 33; inputs changing during stall are ignored.
- LDR ls_in=1, rn=0x100, imm=0x20 -> result=0x120, mem_rd=1, wr_en=1; same with ls_in=0 -> NOP.
- LSL by 32 -> result=0; LSL 1 by 31 -> 0x80000000; valid_in=0 -> valid_out=0 and flags hold.

Source files
------------

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - opcode, instruction field, flag and FSM definitions for execute_stage
package exec_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_ORR = 4'h3;
    localparam logic [3:0] OP_EOR = 4'h4;
    localparam logic [3:0] OP_MOV = 4'h5;
    localparam logic [3:0] OP_LSL = 4'h6;
    localparam logic [3:0] OP_LSR = 4'h7;
    localparam logic [3:0] OP_CMP = 4'h8;
    localparam logic [3:0] OP_MUL = 4'h9;
    localparam logic [3:0] OP_LDR = 4'hA;
    localparam logic [3:0] OP_STR = 4'hB;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int I_BIT  = 27;
    localparam int S_BIT  = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 22;
    localparam int IMM_HI = 13;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = 14;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - register-stage to execute-stage bundle with upstream/stage modports
interface execute_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    logic              valid_in;
    logic              ls_in;
    logic [31:0]       instruction_in;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [REG_AW-1:0] src_a;
    logic [REG_AW-1:0] src_b;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] dest_reg;
    logic              wr_en;
    logic              mem_rd;
    logic              mem_wr;
    logic              valid_out;
    logic [3:0]        flags;
    logic              stall;

    modport master (
        output valid_in, ls_in, instruction_in, op_a, op_b, src_a, src_b,
               wb_valid, wb_reg, wb_data,
        input  result, store_data, dest_reg, wr_en, mem_rd, mem_wr,
               valid_out, flags, stall
    );

    modport slave (
        input  valid_in, ls_in, instruction_in, op_a, op_b, src_a, src_b,
               wb_valid, wb_reg, wb_data,
        output result, store_data, dest_reg, wr_en, mem_rd, mem_wr,
               valid_out, flags, stall
    );
endinterface

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - radix-2 shift-add multiplier, low DATA_W bits of the product
module mul_iter #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [CW-1:0]     cnt;
    logic              busy_q;

    assign busy    = busy_q;
    // done marks the cycle in which the final step is taken; product is already final then
    assign done    = busy_q && (cnt == LAST);
    assign product = acc + (mplier[0] ? mcand : '0);

    // one conditional add and shift per busy cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage: ALU, address generation, forwarding, multiply (EXEC_FAST_MUL_EN selects single-cycle multiply)
module execute_stage
    import exec_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 4,
    parameter int MUL_CYCLES = 32
) (
    input  logic           clk,
    input  logic           reset,
    execute_stage_if.slave bus
);
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] store_q;
    logic [REG_AW-1:0] dest_q;
    logic              wr_en_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              valid_q;
    logic [3:0]        flags_q;

    logic [3:0]        opcode;
    logic              imm_sel;
    logic              set_s;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm_ext;
    logic              unused_fields;

    assign opcode        = bus.instruction_in[OPC_HI:OPC_LO];
    assign imm_sel       = bus.instruction_in[I_BIT];
    assign set_s         = bus.instruction_in[S_BIT];
    assign rd            = REG_AW'(bus.instruction_in[RD_HI:RD_LO]);
    assign imm_ext       = DATA_W'(bus.instruction_in[IMM_HI:IMM_LO]);
    // rn/rm numbers arrive separately on src_a/src_b
    assign unused_fields = ^bus.instruction_in[RD_LO-1:IMM_HI+1];

    logic              ex_fwd_ok;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op2;

    // loads are not forwarded from EX: their result is an address, not the loaded data
    assign ex_fwd_ok = valid_q && wr_en_q && !mem_rd_q;

    // operand forwarding, EX result takes priority over writeback
    always_comb begin
        fwd_a = bus.op_a;
        fwd_b = bus.op_b;
        if (ex_fwd_ok && dest_q == bus.src_a) begin
            fwd_a = result_q;
        end else if (bus.wb_valid && bus.wb_reg == bus.src_a) begin
            fwd_a = bus.wb_data;
        end
        if (ex_fwd_ok && dest_q == bus.src_b) begin
            fwd_b = result_q;
        end else if (bus.wb_valid && bus.wb_reg == bus.src_b) begin
            fwd_b = bus.wb_data;
        end
    end

    assign op2 = imm_sel ? imm_ext : fwd_b;

    logic [DATA_W:0]   add_full;
    logic [DATA_W:0]   sub_full;
    logic [5:0]        sh_amt;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] nz_src;
    logic              res_upd;
    logic              alu_wr;
    logic              alu_mrd;
    logic              alu_mwr;
    logic              flag_upd;
    logic              c_new;
    logic              v_new;

    assign add_full = {1'b0, fwd_a} + {1'b0, op2};
    assign sub_full = {1'b0, fwd_a} - {1'b0, op2};
    assign sh_amt   = op2[5:0];

    // single-cycle operation decode and evaluation
    always_comb begin
        alu_res  = result_q;
        nz_src   = result_q;
        res_upd  = 1'b0;
        alu_wr   = 1'b0;
        alu_mrd  = 1'b0;
        alu_mwr  = 1'b0;
        flag_upd = 1'b0;
        c_new    = flags_q[FLAG_C];
        v_new    = flags_q[FLAG_V];
        case (opcode)
            OP_ADD: begin
                alu_res = add_full[DATA_W-1:0];
                res_upd = 1'b1; alu_wr = 1'b1; flag_upd = set_s;
                c_new   = add_full[DATA_W];
                v_new   = (fwd_a[DATA_W-1] == op2[DATA_W-1]) &&
                          (add_full[DATA_W-1] != fwd_a[DATA_W-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_full[DATA_W-1:0];
                res_upd = (opcode == OP_SUB);
                alu_wr  = (opcode == OP_SUB);
                flag_upd = set_s || (opcode == OP_CMP);
                c_new   = !sub_full[DATA_W];
                v_new   = (fwd_a[DATA_W-1] != op2[DATA_W-1]) &&
                          (sub_full[DATA_W-1] != fwd_a[DATA_W-1]);
            end
            OP_AND: begin alu_res = fwd_a & op2; res_upd = 1'b1; alu_wr = 1'b1; flag_upd = set_s; end
            OP_ORR: begin alu_res = fwd_a | op2; res_upd = 1'b1; alu_wr = 1'b1; flag_upd = set_s; end
            OP_EOR: begin alu_res = fwd_a ^ op2; res_upd = 1'b1; alu_wr = 1'b1; flag_upd = set_s; end
            OP_MOV: begin alu_res = op2;         res_upd = 1'b1; alu_wr = 1'b1; flag_upd = set_s; end
            OP_LSL: begin
                alu_res = (sh_amt >= 6'(DATA_W)) ? '0 : (fwd_a << sh_amt);
                res_upd = 1'b1; alu_wr = 1'b1; flag_upd = set_s;
            end
            OP_LSR: begin
                alu_res = (sh_amt >= 6'(DATA_W)) ? '0 : (fwd_a >> sh_amt);
                res_upd = 1'b1; alu_wr = 1'b1; flag_upd = set_s;
            end
`ifdef EXEC_FAST_MUL_EN
            OP_MUL: begin alu_res = fwd_a * op2; res_upd = 1'b1; alu_wr = 1'b1; flag_upd = set_s; end
`endif
            OP_LDR: begin
                if (bus.ls_in) begin
                    alu_res = fwd_a + imm_ext; res_upd = 1'b1; alu_wr = 1'b1; alu_mrd = 1'b1;
                end
            end
            OP_STR: begin
                if (bus.ls_in) begin
                    alu_res = fwd_a + imm_ext; res_upd = 1'b1; alu_mwr = 1'b1;
                end
            end
            default: ;
        endcase
        if (opcode != OP_CMP) begin
            nz_src = alu_res;
        end else begin
            nz_src = sub_full[DATA_W-1:0];
        end
    end

    logic              accept;
    logic              mul_issue;
    logic              mul_fin;
    logic [DATA_W-1:0] mul_product;
    logic [REG_AW-1:0] mul_rd_q;
    logic              mul_s_q;
    logic              stall;

`ifdef EXEC_FAST_MUL_EN
    assign accept      = 1'b1;
    assign mul_issue   = 1'b0;
    assign mul_fin     = 1'b0;
    assign mul_product = '0;
    assign mul_rd_q    = '0;
    assign mul_s_q     = 1'b0;
    assign stall       = 1'b0;
`else
    mul_state_t state_q;
    mul_state_t state_d;
    logic       mul_busy;
    logic       mul_done;
    logic       stall_raw;

    mul_iter #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_issue),
        .a       (fwd_a),
        .b       (op2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // multiply sequencing state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and stall; DONE accepts new work exactly like IDLE
    always_comb begin
        state_d   = state_q;
        stall_raw = 1'b0;
        mul_issue = 1'b0;
        mul_fin   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.valid_in && opcode == OP_MUL) begin
                    state_d   = ST_BUSY;
                    stall_raw = 1'b1;
                    mul_issue = !reset;
                end
            end
            ST_BUSY: begin
                stall_raw = mul_busy;
                if (mul_done) begin
                    state_d = ST_DONE;
                    mul_fin = 1'b1;
                end else if (!mul_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = (state_q != ST_BUSY);
    assign stall  = stall_raw && !reset;

    // destination and S bit are captured at issue since inputs are free to change afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_rd_q <= '0;
            mul_s_q  <= 1'b0;
        end else if (mul_issue) begin
            mul_rd_q <= rd;
            mul_s_q  <= set_s;
        end
    end
`endif

    // output bundle register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            store_q  <= '0;
            dest_q   <= '0;
            wr_en_q  <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            valid_q  <= 1'b0;
            flags_q  <= '0;
        end else if (mul_fin) begin
            result_q <= mul_product;
            dest_q   <= mul_rd_q;
            wr_en_q  <= 1'b1;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            valid_q  <= 1'b1;
            if (mul_s_q) begin
                flags_q[FLAG_N] <= mul_product[DATA_W-1];
                flags_q[FLAG_Z] <= (mul_product == '0);
            end
        end else if (accept) begin
            valid_q  <= bus.valid_in && !mul_issue;
            wr_en_q  <= bus.valid_in && !mul_issue && alu_wr;
            mem_rd_q <= bus.valid_in && !mul_issue && alu_mrd;
            mem_wr_q <= bus.valid_in && !mul_issue && alu_mwr;
            if (bus.valid_in && !mul_issue) begin
                dest_q  <= rd;
                store_q <= fwd_b;
                if (res_upd) begin
                    result_q <= alu_res;
                end
                if (flag_upd) begin
                    flags_q[FLAG_N] <= nz_src[DATA_W-1];
                    flags_q[FLAG_Z] <= (nz_src == '0);
                    flags_q[FLAG_C] <= c_new;
                    flags_q[FLAG_V] <= v_new;
                end
            end
        end
    end

    assign bus.result     = result_q;
    assign bus.store_data = store_q;
    assign bus.dest_reg   = dest_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.valid_out  = valid_q;
    assign bus.flags      = flags_q;
    assign bus.stall      = stall;
endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed vector bench for execute_stage (default iterative multiply build)
module tb_execute_stage;
    import exec_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    execute_stage_if #(.DATA_W(32), .REG_AW(4)) bus ();

    execute_stage #(.DATA_W(32), .REG_AW(4), .MUL_CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        vin;
        logic        ls;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_res;
        logic [3:0]  e_fl;
        logic        e_val;
        logic        e_wr;
        logic        e_mrd;
        logic        e_mwr;
        logic        chk_st;
        logic [31:0] e_st;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] mk(input logic [3:0] op, input logic i, input logic s,
                                       input logic [3:0] rd, input logic [13:0] imm);
        return {op, i, s, rd, 8'h00, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vin, input logic ls, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sa, input logic [3:0] sb,
                         input logic wbv, input logic [3:0] wbr, input logic [31:0] wbd);
        @(negedge clk);
        bus.valid_in = vin; bus.ls_in = ls; bus.instruction_in = ins;
        bus.op_a = a; bus.op_b = b; bus.src_a = sa; bus.src_b = sb;
        bus.wb_valid = wbv; bus.wb_reg = wbr; bus.wb_data = wbd;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] rd, input logic [31:0] exp);
        int stall_cnt;
        int done_cyc;
        drive(1'b1, 1'b0, mk(OP_MUL, 1'b0, 1'b0, rd, 14'h0), a, b, 4'd14, 4'd15, 1'b0, 4'd0, 32'h0);
        #1;
        chk("mul_issue_stall", {31'b0, bus.stall}, 32'd1);
        stall_cnt = 1;
        done_cyc  = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (bus.valid_out) begin
                done_cyc = i;
                break;
            end
            if (bus.stall) stall_cnt++;
            bus.instruction_in = mk(OP_ADD, 1'b0, 1'b1, 4'd9, 14'h0);
            bus.op_a = 32'(i);
            bus.op_b = 32'h1000;
        end
        chk("mul_latency", done_cyc, 32'd33);
        chk("mul_stall_cycles", stall_cnt, 32'd33);
        chk("mul_result", bus.result, exp);
        chk("mul_wr_en", {31'b0, bus.wr_en}, 32'd1);
        chk("mul_dest", {28'b0, bus.dest_reg}, {28'b0, rd});
        chk("mul_done_stall", {31'b0, bus.stall}, 32'd0);
        bus.valid_in = 1'b0;
    endtask

    initial begin
        int late_valid;
        vec_t v;
        bus.valid_in = 0; bus.ls_in = 0; bus.instruction_in = 0; bus.op_a = 0; bus.op_b = 0;
        bus.src_a = 0; bus.src_b = 0; bus.wb_valid = 0; bus.wb_reg = 0; bus.wb_data = 0;

        // vin ls ins a b | result flags valid wr mrd mwr chk_st store
        vq.push_back('{1'b1, 1'b0, mk(OP_ADD, 1'b0, 1'b1, 4'd1, 14'h0), 32'h7FFFFFFF, 32'h1,
                       32'h80000000, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_CMP, 1'b0, 1'b0, 4'd2, 14'h0), 32'h5, 32'h5,
                       32'h80000000, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_SUB, 1'b0, 1'b0, 4'd1, 14'h0), 32'h3, 32'h5,
                       32'hFFFFFFFE, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_SUB, 1'b0, 1'b1, 4'd1, 14'h0), 32'h3, 32'h5,
                       32'hFFFFFFFE, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_AND, 1'b0, 1'b0, 4'd2, 14'h0), 32'hF0F0, 32'hFF00,
                       32'h0000F000, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_ORR, 1'b1, 1'b0, 4'd3, 14'h00F), 32'h100, 32'h777,
                       32'h0000010F, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_EOR, 1'b0, 1'b1, 4'd1, 14'h0), 32'hFFFF0000, 32'hFFFFFFFF,
                       32'h0000FFFF, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_MOV, 1'b1, 1'b0, 4'd2, 14'h3FFF), 32'hAAAA, 32'h0,
                       32'h00003FFF, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_LSL, 1'b0, 1'b0, 4'd1, 14'h0), 32'h1, 32'd31,
                       32'h80000000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_LSL, 1'b0, 1'b1, 4'd1, 14'h0), 32'h1, 32'd32,
                       32'h00000000, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_LSR, 1'b1, 1'b0, 4'd2, 14'h4), 32'h80000000, 32'h0,
                       32'h08000000, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_LSL, 1'b0, 1'b0, 4'd3, 14'h0), 32'h5, 32'h40,
                       32'h00000005, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_ADD, 1'b0, 1'b1, 4'd1, 14'h0), 32'hFFFFFFFF, 32'h1,
                       32'h00000000, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_ADD, 1'b0, 1'b1, 4'd1, 14'h0), 32'h80000000, 32'h80000000,
                       32'h00000000, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_SUB, 1'b0, 1'b1, 4'd2, 14'h0), 32'h80000000, 32'h1,
                       32'h7FFFFFFF, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, mk(OP_LDR, 1'b0, 1'b0, 4'd3, 14'h20), 32'h100, 32'h999,
                       32'h00000120, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_LDR, 1'b0, 1'b0, 4'd3, 14'h20), 32'h400, 32'h999,
                       32'h00000120, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, mk(OP_STR, 1'b0, 1'b0, 4'd4, 14'h4), 32'h200, 32'hDEAD,
                       32'h00000204, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD});
        vq.push_back('{1'b1, 1'b0, mk(4'hC, 1'b0, 1'b1, 4'd1, 14'h0), 32'h1, 32'h1,
                       32'h00000204, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b0, 1'b0, mk(OP_ADD, 1'b0, 1'b1, 4'd1, 14'h0), 32'h1, 32'h1,
                       32'h00000204, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, mk(OP_LSR, 1'b0, 1'b1, 4'd1, 14'h0), 32'h1, 32'd33,
                       32'h00000000, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", bus.result, 32'h0);
        chk("rst_valid", {31'b0, bus.valid_out}, 32'd0);
        chk("rst_flags", {28'b0, bus.flags}, 32'd0);
        chk("rst_stall", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < vq.size(); k++) begin
            v = vq[k];
            drive(v.vin, v.ls, v.ins, v.a, v.b, 4'd14, 4'd15, 1'b0, 4'd0, 32'h0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_result", k), bus.result, v.e_res);
            chk($sformatf("v%0d_flags", k), {28'b0, bus.flags}, {28'b0, v.e_fl});
            chk($sformatf("v%0d_valid", k), {31'b0, bus.valid_out}, {31'b0, v.e_val});
            chk($sformatf("v%0d_wr_en", k), {31'b0, bus.wr_en}, {31'b0, v.e_wr});
            chk($sformatf("v%0d_mem_rd", k), {31'b0, bus.mem_rd}, {31'b0, v.e_mrd});
            chk($sformatf("v%0d_mem_wr", k), {31'b0, bus.mem_wr}, {31'b0, v.e_mwr});
            if (v.e_wr) chk($sformatf("v%0d_dest", k), {28'b0, bus.dest_reg}, {28'b0, v.ins[25:22]});
            if (v.chk_st) chk($sformatf("v%0d_store", k), bus.store_data, v.e_st);
        end

        // forwarding: EX beats WB, WB alone, loads not forwarded from EX
        drive(1'b1, 1'b0, mk(OP_ADD, 1'b0, 1'b0, 4'd1, 14'h0), 32'd10, 32'd20, 4'd2, 4'd3, 1'b0, 4'd0, 32'h0);
        @(posedge clk); #1;
        chk("fwd_base", bus.result, 32'd30);
        drive(1'b1, 1'b0, mk(OP_ADD, 1'b0, 1'b0, 4'd4, 14'h0), 32'hBAD, 32'hBAD, 4'd1, 4'd1, 1'b1, 4'd1, 32'h10);
        @(posedge clk); #1;
        chk("fwd_ex_over_wb", bus.result, 32'd60);
        drive(1'b1, 1'b0, mk(OP_ADD, 1'b0, 1'b0, 4'd5, 14'h0), 32'hBAD, 32'h2, 4'd1, 4'd6, 1'b1, 4'd1, 32'h10);
        @(posedge clk); #1;
        chk("fwd_wb", bus.result, 32'h12);
        drive(1'b1, 1'b1, mk(OP_LDR, 1'b0, 1'b0, 4'd6, 14'h0), 32'h300, 32'h0, 4'd7, 4'd8, 1'b0, 4'd0, 32'h0);
        @(posedge clk); #1;
        chk("fwd_ldr_addr", bus.result, 32'h300);
        drive(1'b1, 1'b0, mk(OP_ADD, 1'b0, 1'b0, 4'd8, 14'h0), 32'h5, 32'h1, 4'd6, 4'd9, 1'b0, 4'd0, 32'h0);
        @(posedge clk); #1;
        chk("fwd_no_ldr", bus.result, 32'h6);

        // iterative multiply, then hold, then full-width product
        run_mul(32'd7, 32'd6, 4'd5, 32'd42);
        @(posedge clk); #1;
        chk("mul_after_valid", {31'b0, bus.valid_out}, 32'd0);
        chk("mul_after_hold", bus.result, 32'd42);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6, 32'h1);

        // reset in the middle of a multiply
        drive(1'b1, 1'b0, mk(OP_MUL, 1'b0, 1'b1, 4'd7, 14'h0), 32'd3, 32'd4, 4'd14, 4'd15, 1'b0, 4'd0, 32'h0);
        repeat (11) @(posedge clk);
        #1;
        chk("busy_before_reset", {31'b0, bus.stall}, 32'd1);
        bus.valid_in = 1'b0;
        reset = 1'b1;
        #1;
        chk("mrst_result", bus.result, 32'h0);
        chk("mrst_valid", {31'b0, bus.valid_out}, 32'd0);
        chk("mrst_wr_en", {31'b0, bus.wr_en}, 32'd0);
        chk("mrst_dest", {28'b0, bus.dest_reg}, 32'd0);
        chk("mrst_flags", {28'b0, bus.flags}, 32'd0);
        chk("mrst_stall", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, mk(OP_ADD, 1'b0, 1'b1, 4'd2, 14'h0), 32'd2, 32'd3, 4'd14, 4'd15, 1'b0, 4'd0, 32'h0);
        @(posedge clk); #1;
        chk("post_rst_add", bus.result, 32'd5);
        chk("post_rst_valid", {31'b0, bus.valid_out}, 32'd1);
        chk("post_rst_flags", {28'b0, bus.flags}, 32'd0);
        bus.valid_in = 1'b0;
        late_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.valid_out) late_valid++;
        end
        chk("no_aborted_mul_output", late_valid, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
